tap_controller: RTL

- IEEE 1149.1 TAP controller for the drop-in JTAG block. It sequences all test data registers, including the device identification register.
- Contains the 16-state TAP FSM, a 4-bit instruction register, instruction decode, the 1-bit bypass register and the registered TDO mux.
- Generates captureDR/shiftDR/updateDR/clockDR for DR-side registers and selects which DR's serial output drives the chip tdo pin.

---
 rtl/jtag_pkg.sv | 32 +++
 rtl/tap_fsm.sv | 36 +++
 rtl/tap_controller.sv | 81 ++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings and instruction opcodes.
package jtag_pkg;

  // Standard 1149.1 state encodings
  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  localparam logic [3:0] IR_CAPTURE = 4'b0001;
  localparam logic [3:0] IDCODE_OP  = 4'b0001;
  localparam logic [3:0] BYPASS_OP  = 4'b1111;

  function automatic logic is_shift(input tap_state_t s);
    return (s == SH_DR) || (s == SH_IR);
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller state machine; next state depends only on tms.
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  output tap_state_t tap_state
);

  always_ff @(posedge tck) begin
    if (reset) begin
      tap_state <= TLR;
    end else begin
      case (tap_state)
        TLR:      tap_state <= tms ? TLR    : RTI;
        RTI:      tap_state <= tms ? SEL_DR : RTI;
        SEL_DR:   tap_state <= tms ? SEL_IR : CAP_DR;
        CAP_DR:   tap_state <= tms ? EX1_DR : SH_DR;
        SH_DR:    tap_state <= tms ? EX1_DR : SH_DR;
        EX1_DR:   tap_state <= tms ? UPD_DR : PAUSE_DR;
        PAUSE_DR: tap_state <= tms ? EX2_DR : PAUSE_DR;
        EX2_DR:   tap_state <= tms ? UPD_DR : SH_DR;
        UPD_DR:   tap_state <= tms ? SEL_DR : RTI;
        SEL_IR:   tap_state <= tms ? TLR    : CAP_IR;
        CAP_IR:   tap_state <= tms ? EX1_IR : SH_IR;
        SH_IR:    tap_state <= tms ? EX1_IR : SH_IR;
        EX1_IR:   tap_state <= tms ? UPD_IR : PAUSE_IR;
        PAUSE_IR: tap_state <= tms ? EX2_IR : PAUSE_IR;
        EX2_IR:   tap_state <= tms ? UPD_IR : SH_IR;
        UPD_IR:   tap_state <= tms ? SEL_DR : RTI;
      endcase
    end
  end

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: FSM, instruction register, decode, bypass
// register, DR strobes and the negedge-registered TDO mux.
module tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0]  IR_CAPTURE = jtag_pkg::IR_CAPTURE,
  parameter logic [IR_WIDTH-1:0]  IDCODE_OP  = jtag_pkg::IDCODE_OP,
  parameter logic [IR_WIDTH-1:0]  BYPASS_OP  = jtag_pkg::BYPASS_OP
) (
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  input  logic       tdi,
  input  logic       tdo_idcode,
  output logic       tdo,
  output logic       tdo_en,
  output logic       captureDR,
  output logic       shiftDR,
  output logic       updateDR,
  output logic       clockDR,
  output logic       sel_idcode,
  output logic       sel_bypass,
  output logic [3:0] tap_state
);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_stage;
  logic [IR_WIDTH-1:0] instr;
  logic                bypass_reg;
  logic                clk_en_q;

  tap_fsm u_fsm (
    .tck       (tck),
    .reset     (reset),
    .tms       (tms),
    .tap_state (state)
  );

  assign tap_state  = state;
  assign captureDR  = (state == CAP_DR);
  assign shiftDR    = (state == SH_DR);
  assign updateDR   = (state == UPD_DR);
  assign sel_idcode = (instr == IDCODE_OP);
  // Undefined opcodes fall back to bypass
  assign sel_bypass = (instr == BYPASS_OP) || !sel_idcode;

  // Enable changes only while tck is low, so the gated clock cannot glitch
  assign clockDR = tck & clk_en_q;

  always_ff @(posedge tck) begin
    if (reset) begin
      ir_stage   <= IR_CAPTURE;
      instr      <= IDCODE_OP;
      bypass_reg <= 1'b0;
    end else begin
      case (state)
        CAP_IR: ir_stage <= IR_CAPTURE;
        SH_IR:  ir_stage <= {tdi, ir_stage[IR_WIDTH-1:1]};
        UPD_IR: instr    <= ir_stage;
        CAP_DR: if (sel_bypass) bypass_reg <= 1'b0;
        SH_DR:  if (sel_bypass) bypass_reg <= tdi;
        TLR:    instr    <= IDCODE_OP;
        // SEL_IR with tms high is the only tms-driven entry into TLR
        SEL_IR: if (tms) instr <= IDCODE_OP;
        default: ;
      endcase
    end
  end

  always_ff @(negedge tck) begin
    clk_en_q <= (state == CAP_DR) || (state == SH_DR);
    tdo_en   <= is_shift(state);
    case (state)
      SH_IR:   tdo <= ir_stage[0];
      SH_DR:   tdo <= sel_idcode ? tdo_idcode : bypass_reg;
      default: tdo <= 1'b0;
    endcase
  end

endmodule
